// File: rtl/stack_seq_ctrl.sv
// Stack sequencer for CALL / RET / RTI and interrupt entry.
// Stalls the front end while the 32-bit PC (and flags for interrupts) is
// pushed or popped as 16-bit words, owns the stack pointer, and reports the
// resulting PC/flags in a single commit cycle.
module stack_seq_ctrl #(
    parameter int unsigned       ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] SP_INIT    = '1,
    parameter logic [31:0]       INT_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op_type,
    input  logic              int_req,
    input  logic [31:0]       ret_pc,
    input  logic [31:0]       target_pc,
    input  logic [3:0]        flags_in,
    input  logic              mem_ready,
    input  logic [15:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W-1:0] sp,
    output logic              stall,
    output logic              pc_load,
    output logic [31:0]       pc_out,
    output logic              flags_load,
    output logic [3:0]        flags_out,
    output logic              int_ack,
    output logic              done,
    output logic              stack_err
);

    typedef enum logic [2:0] {
        IDLE, PUSH_F, PUSH_H, PUSH_L, POP_L, POP_H, POP_F, COMMIT
    } state_t;

    typedef enum logic [1:0] {K_CALL, K_RET, K_RTI, K_INT} kind_t;

    state_t      state, state_d;
    kind_t       kind, kind_d;
    logic [31:0] rpc, rpc_d, tpc, tpc_d;
    logic [3:0]  fin, fin_d, fpop, fpop_d;
    logic [15:0] lo, lo_d, hi, hi_d;
    logic [ADDR_W-1:0] sp_d;
    logic        err_d;

    logic              push_d, pop_d, commit_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [15:0]       mem_wdata_d;
    logic [31:0]       pc_out_d;
    logic [3:0]        flags_out_d;

    // Next state, stack pointer and latched operands; outputs are derived from
    // the next state so they can be registered alongside it.
    always_comb begin
        state_d = state;
        kind_d  = kind;
        rpc_d   = rpc;
        tpc_d   = tpc;
        fin_d   = fin;
        fpop_d  = fpop;
        lo_d    = lo;
        hi_d    = hi;
        sp_d    = sp;
        err_d   = stack_err;

        case (state)
            IDLE: begin
                if (op_valid && op_type != 2'b00) begin
                    rpc_d = ret_pc;
                    tpc_d = target_pc;
                    fin_d = flags_in;
                    case (op_type)
                        2'b01:   kind_d = K_CALL;
                        2'b10:   kind_d = K_RET;
                        default: kind_d = K_RTI;
                    endcase
                    state_d = (op_type == 2'b01) ? PUSH_H : POP_L;
                end else if (int_req) begin
                    rpc_d   = ret_pc;
                    tpc_d   = target_pc;
                    fin_d   = flags_in;
                    kind_d  = K_INT;
                    state_d = PUSH_F;
                end
            end
            PUSH_F, PUSH_H, PUSH_L: begin
                if (mem_ready) begin
                    if (sp == '0) err_d = 1'b1;
                    sp_d = sp - ADDR_W'(1);
                    case (state)
                        PUSH_F:  state_d = PUSH_H;
                        PUSH_H:  state_d = PUSH_L;
                        default: state_d = COMMIT;
                    endcase
                end
            end
            POP_L, POP_H, POP_F: begin
                if (mem_ready) begin
                    if (sp == SP_INIT) err_d = 1'b1;
                    sp_d = sp + ADDR_W'(1);
                    case (state)
                        POP_L: begin
                            lo_d    = mem_rdata;
                            state_d = POP_H;
                        end
                        POP_H: begin
                            hi_d    = mem_rdata;
                            state_d = (kind == K_RTI) ? POP_F : COMMIT;
                        end
                        default: begin
                            fpop_d  = mem_rdata[3:0];
                            state_d = COMMIT;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        push_d   = (state_d == PUSH_F) || (state_d == PUSH_H) || (state_d == PUSH_L);
        pop_d    = (state_d == POP_L) || (state_d == POP_H) || (state_d == POP_F);
        commit_d = (state_d == COMMIT);

        mem_addr_d = '0;
        if (pop_d)       mem_addr_d = sp_d + ADDR_W'(1);
        else if (push_d) mem_addr_d = sp_d;

        case (state_d)
            PUSH_F:  mem_wdata_d = {12'b0, fin_d};
            PUSH_H:  mem_wdata_d = rpc_d[31:16];
            PUSH_L:  mem_wdata_d = rpc_d[15:0];
            default: mem_wdata_d = '0;
        endcase

        pc_out_d = pc_out;
        if (commit_d) begin
            case (kind_d)
                K_CALL:  pc_out_d = tpc_d;
                K_INT:   pc_out_d = INT_VECTOR;
                default: pc_out_d = {hi_d, lo_d};
            endcase
        end

        flags_out_d = flags_out;
        if (commit_d && kind_d == K_RTI) flags_out_d = fpop_d;
    end

    // State, stack pointer, latched operands and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            kind       <= K_CALL;
            rpc        <= '0;
            tpc        <= '0;
            fin        <= '0;
            fpop       <= '0;
            lo         <= '0;
            hi         <= '0;
            sp         <= SP_INIT;
            stack_err  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            stall      <= 1'b0;
            pc_load    <= 1'b0;
            pc_out     <= '0;
            flags_load <= 1'b0;
            flags_out  <= '0;
            int_ack    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            kind       <= kind_d;
            rpc        <= rpc_d;
            tpc        <= tpc_d;
            fin        <= fin_d;
            fpop       <= fpop_d;
            lo         <= lo_d;
            hi         <= hi_d;
            sp         <= sp_d;
            stack_err  <= err_d;
            mem_req    <= push_d || pop_d;
            mem_we     <= push_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            stall      <= (state_d != IDLE);
            pc_load    <= commit_d;
            done       <= commit_d;
            int_ack    <= commit_d && (kind_d == K_INT);
            flags_load <= commit_d && (kind_d == K_RTI);
            pc_out     <= pc_out_d;
            flags_out  <= flags_out_d;
        end
    end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Bench for stack_seq_ctrl: directed cases followed by randomized operations,
// each checked against a word-level stack model held in the bench.
module tb_stack_seq_ctrl;

    localparam int K_NONE = 0, K_CALL = 1, K_RET = 2, K_RTI = 3, K_INT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [1:0]  op_type;
    logic        int_req;
    logic [31:0] ret_pc, target_pc;
    logic [3:0]  flags_in;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr, sp;
    logic [15:0] mem_wdata;
    logic        stall, pc_load, flags_load, int_ack, done, stack_err;
    logic [31:0] pc_out;
    logic [3:0]  flags_out;

    stack_seq_ctrl #(.ADDR_W(12), .SP_INIT(12'hFFF), .INT_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_type(op_type),
        .int_req(int_req), .ret_pc(ret_pc), .target_pc(target_pc),
        .flags_in(flags_in), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .sp(sp), .stall(stall), .pc_load(pc_load),
        .pc_out(pc_out), .flags_load(flags_load), .flags_out(flags_out),
        .int_ack(int_ack), .done(done), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Memory environment seen by the DUT
    bit [15:0] env_mem [0:4095];
    always @(posedge clk) if (mem_req && mem_we && mem_ready) env_mem[mem_addr] <= mem_wdata;
    always_comb mem_rdata = env_mem[mem_addr];

    // Reference stack model
    bit [15:0]   ref_mem [0:4095];
    logic [11:0] m_sp;
    bit          m_err;

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [15:0] data;
    } acc_t;

    int n_checks = 0;
    int n_pass   = 0;
    int hold_left;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit pick_ready(input int mode, input int idx);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2 && idx == 1 && hold_left > 0) begin
            hold_left--;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Called at the first negedge after acceptance; returns at the commit negedge.
    task automatic expect_seq(input int kind, input logic [31:0] r, input logic [31:0] t,
                              input logic [3:0] f, input int mode, input int exp_lat);
        acc_t        q[$];
        acc_t        a;
        logic [15:0] w[$];
        logic [15:0] rd[3];
        logic [31:0] epc;
        logic [3:0]  efl;
        logic [11:0] run_sp;
        int          n_acc, cyc, waits, idx;
        bit          seen, rdy;

        run_sp = m_sp;
        epc = 32'h0;
        efl = 4'h0;
        if (kind == K_CALL || kind == K_INT) begin
            if (kind == K_INT) w.push_back({12'b0, f});
            w.push_back(r[31:16]);
            w.push_back(r[15:0]);
            foreach (w[i]) begin
                if (m_sp == 12'h000) m_err = 1'b1;
                a.we = 1'b1; a.addr = m_sp; a.data = w[i];
                q.push_back(a);
                ref_mem[m_sp] = w[i];
                m_sp = m_sp - 12'd1;
            end
            epc = (kind == K_CALL) ? t : 32'h0000_0000;
        end else begin
            for (int i = 0; i < ((kind == K_RTI) ? 3 : 2); i++) begin
                if (m_sp == 12'hFFF) m_err = 1'b1;
                m_sp = m_sp + 12'd1;
                a.we = 1'b0; a.addr = m_sp; a.data = 16'h0;
                q.push_back(a);
                rd[i] = ref_mem[m_sp];
            end
            epc = {rd[1], rd[0]};
            if (kind == K_RTI) efl = rd[2][3:0];
        end

        n_acc = q.size();
        cyc = 0; waits = 0; idx = 0; seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            cyc++;
            check("stall_busy", stall, 1'b1);
            check("sp_track", sp, run_sp);
            if (q.size() > 0) begin
                a = q[0];
                check("mem_req", mem_req, 1'b1);
                check("mem_we", mem_we, a.we);
                check("mem_addr", mem_addr, a.addr);
                if (a.we) check("mem_wdata", mem_wdata, a.data);
                check("pc_load_early", pc_load, 1'b0);
                rdy = pick_ready(mode, idx);
                mem_ready = rdy;
                if (rdy) begin
                    void'(q.pop_front());
                    run_sp = a.we ? run_sp - 12'd1 : run_sp + 12'd1;
                    idx++;
                end else begin
                    waits++;
                end
                @(negedge clk);
            end else begin
                mem_ready = 1'b0;
                check("commit_mem_req", mem_req, 1'b0);
                check("pc_load", pc_load, 1'b1);
                check("done", done, 1'b1);
                check("pc_out", pc_out, epc);
                check("int_ack", int_ack, kind == K_INT);
                check("flags_load", flags_load, kind == K_RTI);
                if (kind == K_RTI) check("flags_out", flags_out, efl);
                check("stack_err", stack_err, m_err);
                check("latency", cyc, n_acc + waits + 1);
                if (exp_lat != 0) check("latency_exact", cyc, exp_lat);
                if (kind == K_INT) int_req = 1'b0;
                seen = 1'b1;
            end
        end
        if (!seen) begin
            check("timeout", 1'b1, 1'b0);
            int_req = 1'b0;
        end
    endtask

    task automatic idle_check();
        check("idle_stall", stall, 1'b0);
        check("idle_pc_load", pc_load, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_mem_req", mem_req, 1'b0);
        check("idle_sp", sp, m_sp);
    endtask

    task automatic run_op(input int kind, input logic [31:0] r, input logic [31:0] t,
                          input logic [3:0] f, input int mode, input int lat);
        hold_left = 3;
        ret_pc = r; target_pc = t; flags_in = f; mem_ready = 1'b0;
        if (kind == K_INT) int_req = 1'b1;
        else begin
            op_valid = 1'b1;
            op_type  = 2'(kind);
        end
        @(negedge clk);
        // scramble inputs after acceptance: the DUT must use its latched copies
        op_valid = 1'b0; op_type = 2'($urandom);
        ret_pc = $urandom; target_pc = $urandom; flags_in = 4'($urandom);
        expect_seq(kind, r, t, f, mode, lat);
        @(negedge clk);
        idle_check();
    endtask

    task automatic ignored_op();
        op_valid = 1'b1; op_type = 2'b00;
        @(negedge clk);
        op_valid = 1'b0;
        idle_check();
        @(negedge clk);
        idle_check();
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_type = 2'b00; int_req = 1'b0;
        ret_pc = '0; target_pc = '0; flags_in = '0; mem_ready = 1'b0;
        m_sp = 12'hFFF; m_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sp", sp, 12'hFFF);
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_pc_load", pc_load, 1'b0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_int_ack", int_ack, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_flags_out", flags_out, 4'h0);
        check("rst_stack_err", stack_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // CALL then RET, INT then RTI, all with memory always ready
        run_op(K_CALL, 32'h1234_5678, 32'h0000_0040, 4'h0, 0, 3);
        check("ram_hi", ref_mem[12'hFFF], 16'h1234);
        run_op(K_RET, 32'h0, 32'h0, 4'h0, 0, 3);
        check("sp_after_ret", sp, 12'hFFF);
        run_op(K_INT, 32'h0000_0100, 32'h0, 4'b1010, 0, 4);
        run_op(K_RTI, 32'h0, 32'h0, 4'h0, 0, 4);
        check("sp_after_rti", sp, 12'hFFF);
        ignored_op();

        // CALL and int_req in the same cycle: CALL first, INT right after
        ret_pc = 32'hAAAA_5555; target_pc = 32'h0000_0200; flags_in = 4'h3;
        op_valid = 1'b1; op_type = 2'b01; int_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        op_valid = 1'b0;
        expect_seq(K_CALL, 32'hAAAA_5555, 32'h0000_0200, 4'h3, 0, 3);
        @(negedge clk);
        check("combo_idle_stall", stall, 1'b0);
        ret_pc = 32'h0000_0300; flags_in = 4'h6;
        @(negedge clk);
        expect_seq(K_INT, 32'h0000_0300, 32'h0, 4'h6, 0, 4);
        @(negedge clk);
        idle_check();
        run_op(K_RTI, 32'h0, 32'h0, 4'h0, 0, 4);
        run_op(K_RET, 32'h0, 32'h0, 4'h0, 0, 3);

        // mem_ready held low for three cycles during PUSH_L
        run_op(K_CALL, 32'hCAFE_BEEF, 32'h0000_0800, 4'h0, 2, 6);

        // reset in the middle of an interrupt entry
        ret_pc = 32'h0000_0444; flags_in = 4'h5; int_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        ref_mem[m_sp] = 16'h0005;
        @(negedge clk);
        mem_ready = 1'b0; int_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_sp", sp, 12'hFFF);
        check("midrst_stall", stall, 1'b0);
        check("midrst_mem_req", mem_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_sp = 12'hFFF; m_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_pc_load", pc_load, 1'b0);
            check("midrst_no_int_ack", int_ack, 1'b0);
            check("midrst_idle", stall, 1'b0);
        end

        // underflow: RET with an empty stack
        run_op(K_RET, 32'h0, 32'h0, 4'h0, 0, 3);
        check("underflow_err", stack_err, 1'b1);
        check("underflow_sp", sp, 12'h001);

        // randomized operations with random memory wait states
        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 4);
            if (k == K_NONE) ignored_op();
            else run_op(k, $urandom, $urandom, 4'($urandom), 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_seq_ctrl.md
Name: stack_seq_ctrl

Overview:
Multi-cycle sequencer for stack-based control transfers: CALL, RET, RTI and hardware interrupt entry.
- Stalls the front end while it pushes or pops the 32-bit PC as two 16-bit halves, plus the flags for interrupt entry and RTI.
- Owns the stack pointer.
- Reports the final PC and flags to the fetch stage and the flag register in a single commit cycle.

Parameters:
ADDR_W, 12, stack/data-memory address width
SP_INIT, 12'hFFF, stack pointer reset value (top of stack); stack grows downward
INT_VECTOR, 32'h0000_0000, PC loaded on interrupt entry

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  single-cycle request from decode; sampled only in IDLE
op_type  in  2  00 none, 01 CALL, 10 RET, 11 RTI
int_req  in  1  level interrupt request; held until int_ack
ret_pc  in  32  return PC to push (CALL, INT)
target_pc  in  32  CALL destination
flags_in  in  4  current flags (pushed on INT)
mem_ready  in  1  memory accepts write / returns read data this cycle
mem_rdata  in  16  read data, valid when mem_req & !mem_we & mem_ready
mem_req  out  1  memory access request
mem_we  out  1  1 write (push), 0 read (pop)
mem_addr  out  ADDR_W  access address
mem_wdata  out  16  push data
sp  out  ADDR_W  current stack pointer
stall  out  1  freeze fetch/decode
pc_load  out  1  one-cycle pulse: load pc_out into PC
pc_out  out  32  new PC
flags_load  out  1  one-cycle pulse: load flags_out
flags_out  out  4  restored flags
int_ack  out  1  one-cycle pulse: interrupt taken
done  out  1  one-cycle pulse: sequence complete
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sp=SP_INIT.
  - All outputs 0 except sp; latched PC/flag registers cleared.
  - Reset mid-sequence abandons the operation with no partial commit.
- States: IDLE, PUSH_F, PUSH_H, PUSH_L, POP_L, POP_H, POP_F, COMMIT.
- Acceptance in IDLE:
  - A valid op wins over int_req in the same cycle.
  - op_valid with op_type=00 is ignored.
  - On acceptance, latch ret_pc, target_pc and flags_in.
- Sequences:
  - CALL: PUSH_H → PUSH_L → COMMIT (pc_out=target).
  - RET: POP_L → POP_H → COMMIT (pc_out={hi,lo}).
  - INT (int_req & no op): PUSH_F → PUSH_H → PUSH_L → COMMIT (pc_out=INT_VECTOR, int_ack=1).
  - RTI: POP_L → POP_H → POP_F → COMMIT (pc_out={hi,lo}, flags_load=1, flags_out=popped[3:0]).
- Push state:
  - mem_req=1, mem_we=1, mem_addr=sp.
  - mem_wdata: ret_pc[31:16] in PUSH_H, ret_pc[15:0] in PUSH_L, {12'b0,flags} in PUSH_F.
  - On mem_ready: sp←sp−1, advance.
- Pop state:
  - mem_req=1, mem_we=0, mem_addr=sp+1.
  - On mem_ready: capture mem_rdata, sp←sp+1, advance.
- Handshake:
  - While mem_ready=0, state, address and data hold stable. No timeout.
  - One access completes per cycle at most.
- COMMIT:
  - Lasts one cycle: pc_load=1, done=1, plus int_ack/flags_load per sequence.
  - Returns to IDLE; a new op may be accepted the following cycle.
- stall:
  - Registered; 1 in every non-IDLE state including COMMIT.
  - 0 in IDLE.
- Latency with mem_ready tied 1:
  - Request accepted at edge N; CALL/RET COMMIT at cycle N+3; INT/RTI COMMIT at cycle N+4.
- SP arithmetic:
  - Modulo 2^ADDR_W; wraps silently.
  - stack_err set on a push with sp==0 or a pop with sp==SP_INIT.
  - stack_err is cleared only by reset; the operation still completes.
- Inputs other than mem_ready/mem_rdata are ignored outside IDLE; int_req arriving mid-sequence waits.

Test Plan:
- CALL, ret_pc=32'h1234_5678, target=32'h0000_0040, mem_ready=1 → writes 16'h1234@FFF, 16'h5678@FFE; sp=FFD; pc_load with pc_out=0x40 at cycle 3; stall cycles 1–3.
- RET immediately after → reads @FFE then @FFF; pc_out=32'h1234_5678; sp back to FFF.
- int_req with flags_in=4'b1010, ret_pc=0x100 → pushes 000A@FFF, 0000@FFE, 0100@FFD; pc_out=INT_VECTOR, int_ack pulse. Then RTI → flags_out=1010, pc_out=0x100, sp=FFF.
- op_valid CALL and int_req in the same cycle → CALL runs first; INT is accepted the cycle after CALL's COMMIT.
- mem_ready low 3 cycles during PUSH_L → mem_addr/mem_wdata stable, sp unchanged, COMMIT delayed by exactly 3 cycles.
- RET at reset sp=FFF → stack_err=1, sp wraps to 001; rst_n pulse mid-INT → IDLE, sp=FFF, no pc_load.
